alu_writeback: RTL

- Writeback stage directly downstream of the 8-bit ALU in the tiny CPU pipeline.
- Captures ALU result and flags through a valid/ready handshake and commits flags to the architectural flag register.
- Buffers register-file writes in a 2-entry skid buffer so register-file back-pressure never drops a result.
- Evaluates branch condition codes against the committed flags for the fetch/branch unit.

---
 rtl/alu_writeback_pkg.sv | 68 ++++++
 rtl/alu_writeback_wb_skid_buf.sv | 73 +++++++
 rtl/alu_writeback.sv | 139 +++++++++++++
 3 files changed

// File: rtl/alu_writeback_pkg.sv
// Shared definitions for the ALU writeback stage: opcode and condition-code
// encodings, flag bit positions, skid-buffer state type and helper functions.
// Optional feature macro used by the stage: ALU_WB_FWD_EN (operand bypass ports).
package alu_writeback_pkg;

    localparam int DATA_W_DEF     = 8;
    localparam int REG_ADDR_W_DEF = 3;

    // ALU opcodes as produced by the execute stage
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_SHL = 4'h2;
    localparam logic [3:0] OP_SHR = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;

    // Branch condition codes
    localparam logic [2:0] COND_EQ = 3'd0;
    localparam logic [2:0] COND_NE = 3'd1;
    localparam logic [2:0] COND_CS = 3'd2;
    localparam logic [2:0] COND_CC = 3'd3;
    localparam logic [2:0] COND_MI = 3'd4;
    localparam logic [2:0] COND_PL = 3'd5;
    localparam logic [2:0] COND_VS = 3'd6;
    localparam logic [2:0] COND_AL = 3'd7;

    // Bit positions inside the committed {N,Z,C,V} flag vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

    // True for every opcode the writeback stage is allowed to commit
    function automatic logic is_legal_op(input logic [3:0] op);
        logic legal;
        case (op)
            OP_ADD, OP_SUB, OP_SHL, OP_SHR,
            OP_AND, OP_OR,  OP_XOR:          legal = 1'b1;
            default:                         legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Evaluate a branch condition against a committed flag vector
    function automatic logic eval_cond(input logic [2:0] cond, input logic [3:0] flags);
        logic res;
        case (cond)
            COND_EQ: res =  flags[FLAG_Z];
            COND_NE: res = ~flags[FLAG_Z];
            COND_CS: res =  flags[FLAG_C];
            COND_CC: res = ~flags[FLAG_C];
            COND_MI: res =  flags[FLAG_N];
            COND_PL: res = ~flags[FLAG_N];
            COND_VS: res =  flags[FLAG_V];
            COND_AL: res =  1'b1;
            default: res =  1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_writeback_wb_skid_buf.sv
// Generic 2-entry valid/ready skid buffer (FIFO order). The head entry drives
// the output straight from registers; head and tail are both exposed so the
// parent can bypass the youngest pending entry.
module alu_writeback_wb_skid_buf
    import alu_writeback_pkg::*;
#(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             tail_valid_o,
    output logic [WIDTH-1:0] tail_data_o
);

    skid_state_e      state_q;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic             push_s;
    logic             pop_s;

    assign in_ready_o   = (state_q != SKID_TWO);
    assign out_valid_o  = (state_q != SKID_EMPTY);
    assign out_data_o   = head_q;
    assign tail_valid_o = (state_q == SKID_TWO);
    assign tail_data_o  = tail_q;

    assign push_s = in_valid_i && in_ready_o;
    assign pop_s  = out_valid_o && out_ready_i;

    // Occupancy FSM plus entry storage; a pop from TWO promotes the tail to head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SKID_EMPTY;
            head_q  <= {WIDTH{1'b0}};
            tail_q  <= {WIDTH{1'b0}};
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (push_s) begin
                        head_q  <= in_data_i;
                        state_q <= SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (push_s && pop_s) begin
                        head_q  <= in_data_i;
                    end else if (push_s) begin
                        tail_q  <= in_data_i;
                        state_q <= SKID_TWO;
                    end else if (pop_s) begin
                        state_q <= SKID_EMPTY;
                    end
                end
                SKID_TWO: begin
                    if (pop_s) begin
                        head_q  <= tail_q;
                        state_q <= SKID_ONE;
                    end
                end
                default: begin
                    state_q <= SKID_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: accepts ALU results over valid/ready, commits flags,
// queues register-file writes in a 2-entry skid buffer and evaluates branch
// conditions against the committed flags.
// Optional feature macro: ALU_WB_FWD_EN adds fwd_valid/fwd_addr/fwd_data,
// presenting the youngest buffered write for execute-stage bypass.
module alu_writeback
    import alu_writeback_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_op,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_wb_en,
    input  logic                  in_flag_en,
    input  logic [DATA_W-1:0]     in_result,
    input  logic                  in_zero,
    input  logic                  in_overflow,
    input  logic                  in_carry,
    input  logic                  in_negative,
    output logic                  rf_valid,
    input  logic                  rf_ready,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic [3:0]            flags,
    input  logic [2:0]            cond,
    output logic                  cond_true,
    output logic                  illegal_op
`ifdef ALU_WB_FWD_EN
    ,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_addr,
    output logic [DATA_W-1:0]     fwd_data
`endif
);

    localparam int ENTRY_W = REG_ADDR_W + DATA_W;

    logic               accept_s;
    logic               legal_s;
    logic               push_valid_s;
    logic [ENTRY_W-1:0] head_s;
    logic [3:0]         flags_d;
    logic [3:0]         flags_q;
    logic               illegal_d;
    logic               illegal_q;

`ifdef ALU_WB_FWD_EN
    logic               tail_valid_s;
    logic [ENTRY_W-1:0] tail_s;
`else
    logic               tail_valid_unused_s;
    logic [ENTRY_W-1:0] tail_unused_s;
`endif

    assign legal_s  = is_legal_op(in_op);
    assign accept_s = in_valid && in_ready;
    // Only legal ops with write-back enabled enter the buffer; the buffer's own
    // ready gates the push, so the flag path and the buffer agree on acceptance.
    assign push_valid_s = in_valid && legal_s && in_wb_en;

    alu_writeback_wb_skid_buf #(
        .WIDTH (ENTRY_W)
    ) u_skid (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (push_valid_s),
        .in_ready_o   (in_ready),
        .in_data_i    ({in_rd, in_result}),
        .out_valid_o  (rf_valid),
        .out_ready_i  (rf_ready),
        .out_data_o   (head_s),
`ifdef ALU_WB_FWD_EN
        .tail_valid_o (tail_valid_s),
        .tail_data_o  (tail_s)
`else
        .tail_valid_o (tail_valid_unused_s),
        .tail_data_o  (tail_unused_s)
`endif
    );

    assign rf_waddr = head_s[ENTRY_W-1:DATA_W];
    assign rf_wdata = head_s[DATA_W-1:0];

    // Next flag/illegal state: flags follow accepted legal ops independently of rf_ready
    always_comb begin
        flags_d   = flags_q;
        illegal_d = illegal_q;
        if (accept_s && legal_s && in_flag_en) begin
            flags_d[FLAG_N] = in_negative;
            flags_d[FLAG_Z] = in_zero;
            flags_d[FLAG_C] = in_carry;
            flags_d[FLAG_V] = in_overflow;
        end else if (accept_s && !legal_s) begin
            illegal_d = 1'b1;
        end else begin
            flags_d   = flags_q;
            illegal_d = illegal_q;
        end
    end

    // Architectural flag register and sticky illegal-opcode indicator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q   <= 4'b0000;
            illegal_q <= 1'b0;
        end else begin
            flags_q   <= flags_d;
            illegal_q <= illegal_d;
        end
    end

    assign flags      = flags_q;
    assign illegal_op = illegal_q;

    // Branch condition decode straight from the committed flags
    always_comb begin
        cond_true = eval_cond(cond, flags_q);
    end

`ifdef ALU_WB_FWD_EN
    // Youngest pending write: tail when two entries are held, otherwise head
    always_comb begin
        fwd_valid = rf_valid;
        if (tail_valid_s) begin
            fwd_addr = tail_s[ENTRY_W-1:DATA_W];
            fwd_data = tail_s[DATA_W-1:0];
        end else begin
            fwd_addr = head_s[ENTRY_W-1:DATA_W];
            fwd_data = head_s[DATA_W-1:0];
        end
    end
`endif

endmodule
